// File: rtl/retire_map_if.sv
// retire_map_if: retire-side bundle between the ROB/retire stage and the
// retirement map table.
//   slave  (retire_map): receives retire lanes + flush; drives free_mask,
//          retired_count, recovery snapshot and the sticky error flag.
//   master (retire stage / bench): the opposite directions.
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

interface retire_map_if #(
  parameter int RETIRE_WIDTH = `N,
  parameter int PR_COUNT     = `PHYS_REG_SZ_R10K,
  parameter int AR_COUNT     = `ARCH_REG_SZ
);
  localparam int PR_IDX = $clog2(PR_COUNT);
  localparam int AR_IDX = $clog2(AR_COUNT);
  localparam int CW     = $clog2(RETIRE_WIDTH + 1);

  logic [RETIRE_WIDTH-1:0]             retire_valid;
  logic [RETIRE_WIDTH-1:0]             retire_has_dest;
  logic [RETIRE_WIDTH-1:0][AR_IDX-1:0] retire_arch_reg;
  logic [RETIRE_WIDTH-1:0][PR_IDX-1:0] retire_phys_reg;
  logic                                flush;

  logic [PR_COUNT-1:0]                 free_mask;
  logic [CW-1:0]                       retired_count;
  logic                                recover_valid;
  logic [AR_COUNT-1:0][PR_IDX-1:0]     arch_map;
  logic [PR_COUNT-1:0]                 arch_avail_mask;
  logic                                double_map_err;

  modport slave (
    input  retire_valid, retire_has_dest, retire_arch_reg, retire_phys_reg, flush,
    output free_mask, retired_count, recover_valid, arch_map, arch_avail_mask,
           double_map_err
  );

  modport master (
    output retire_valid, retire_has_dest, retire_arch_reg, retire_phys_reg, flush,
    input  free_mask, retired_count, recover_valid, arch_map, arch_avail_mask,
           double_map_err
  );
endinterface

// File: rtl/retire_map.sv
// retire_map: committed architectural->physical map at the retire end of the
// rename pipeline. Each retiring destination write releases the previously
// committed physical register to the freelist as a one-hot free_mask bit.
// A retire-time flush produces a one-cycle recovery snapshot (committed map +
// availability mask) on the cycle after the flushing retirement.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus          : retire_map_if.slave (retire lanes, flush, free/recover outs)
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

module retire_map #(
  parameter int RETIRE_WIDTH = `N,
  parameter int PR_COUNT     = `PHYS_REG_SZ_R10K,
  parameter int AR_COUNT     = `ARCH_REG_SZ
) (
  input  logic        clock,
  input  logic        reset,
  retire_map_if.slave bus
);
  localparam int PR_IDX = $clog2(PR_COUNT);
  localparam int AR_IDX = $clog2(AR_COUNT);
  localparam int CW     = $clog2(RETIRE_WIDTH + 1);

  typedef logic [AR_COUNT-1:0][PR_IDX-1:0] map_t;

  // Identity map after reset: arch reg i lives in phys reg i, so the low
  // AR_COUNT phys regs start occupied.
  localparam logic [PR_COUNT-1:0] USED_RST = ~({PR_COUNT{1'b1}} << AR_COUNT);

  function automatic map_t map_rst();
    map_t m;
    for (int i = 0; i < AR_COUNT; i++) m[i] = PR_IDX'(i);
    return m;
  endfunction

  map_t                amap_q;
  logic [PR_COUNT-1:0] used_q;
  logic [PR_COUNT-1:0] free_q, free_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rcv_q;
  logic                err_q, err_d;

  // Running copies of map/used threaded through the lanes, oldest first.
  map_t [RETIRE_WIDTH:0]                map_c;
  logic [RETIRE_WIDTH:0][PR_COUNT-1:0]  used_c;
  logic [RETIRE_WIDTH-1:0][PR_COUNT-1:0] free_l;
  logic [RETIRE_WIDTH-1:0]              err_l;

  assign map_c[0]  = amap_q;
  assign used_c[0] = used_q;

  for (genvar l = 0; l < RETIRE_WIDTH; l++) begin : g_lane
    logic [AR_IDX-1:0]   a;
    logic [PR_IDX-1:0]   p, old;
    logic                eff;
    map_t                map_n;
    logic [PR_COUNT-1:0] used_n, free_n;
    logic                err_n;

    assign a   = bus.retire_arch_reg[l];
    assign p   = bus.retire_phys_reg[l];
    assign old = map_c[l][a];
    // x0 writes are dropped entirely: no remap and no free.
    assign eff = bus.retire_valid[l] & bus.retire_has_dest[l] & (a != '0);

    always_comb begin
      map_n  = map_c[l];
      used_n = used_c[l];
      free_n = '0;
      err_n  = 1'b0;
      // p == old is a no-op remap: nothing to free, nothing to flag.
      if (eff && (p != old)) begin
        err_n       = used_c[l][p];
        map_n[a]    = p;
        used_n[old] = 1'b0;
        used_n[p]   = 1'b1;
        free_n[old] = 1'b1;
      end
    end

    assign map_c[l+1]  = map_n;
    assign used_c[l+1] = used_n;
    assign free_l[l]   = free_n;
    assign err_l[l]    = err_n;
  end

  always_comb begin
    free_d = '0;
    err_d  = err_q;
    cnt_d  = '0;
    for (int l = 0; l < RETIRE_WIDTH; l++) begin
      free_d = free_d | free_l[l];
      err_d  = err_d | err_l[l];
      cnt_d  = cnt_d + CW'(bus.retire_valid[l]);
    end
    // Phys reg 0 backs x0 and must never return to the freelist.
    free_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      amap_q <= map_rst();
      used_q <= USED_RST;
      free_q <= '0;
      cnt_q  <= '0;
      rcv_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      amap_q <= map_c[RETIRE_WIDTH];
      used_q <= used_c[RETIRE_WIDTH];
      free_q <= free_d;
      cnt_q  <= cnt_d;
      rcv_q  <= bus.flush;
      err_q  <= err_d;
    end
  end

  assign bus.free_mask       = free_q;
  assign bus.retired_count   = cnt_q;
  assign bus.recover_valid   = rcv_q;
  assign bus.arch_map        = amap_q;
  assign bus.arch_avail_mask = ~used_q;
  assign bus.double_map_err  = err_q;
endmodule

// File: tb/tb_retire_map.sv
// tb_retire_map: directed table-driven checks of retire_map with
// RETIRE_WIDTH=2, PR_COUNT=64, AR_COUNT=32, plus hand sequences for reset
// behaviour.
module tb_retire_map;
  localparam int RW = 2;
  localparam int PRC = 64;
  localparam int ARC = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  retire_map_if #(.RETIRE_WIDTH(RW), .PR_COUNT(PRC), .AR_COUNT(ARC)) bus ();

  retire_map #(.RETIRE_WIDTH(RW), .PR_COUNT(PRC), .AR_COUNT(ARC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  hd;
    logic [4:0]  a0, a1;
    logic [5:0]  p0, p1;
    logic        fl;
    logic [63:0] efree;
    logic [1:0]  ecnt;
    logic        ercv;
    logic        eerr;
    logic [4:0]  ca;
    logic [5:0]  emap;
    logic [63:0] eavail;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  vec_t vecs[12];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] hd, logic [4:0] a0, logic [5:0] p0,
                              logic [4:0] a1, logic [5:0] p1, logic fl,
                              logic [63:0] efree, logic [1:0] ecnt, logic ercv, logic eerr,
                              logic [4:0] ca, logic [5:0] emap, logic [63:0] eavail);
    vec_t t;
    t.v = v; t.hd = hd; t.a0 = a0; t.p0 = p0; t.a1 = a1; t.p1 = p1; t.fl = fl;
    t.efree = efree; t.ecnt = ecnt; t.ercv = ercv; t.eerr = eerr;
    t.ca = ca; t.emap = emap; t.eavail = eavail;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] hd, input logic [4:0] a0,
                       input logic [5:0] p0, input logic [4:0] a1, input logic [5:0] p1,
                       input logic fl);
    bus.retire_valid       = v;
    bus.retire_has_dest    = hd;
    bus.retire_arch_reg[0] = a0;
    bus.retire_arch_reg[1] = a1;
    bus.retire_phys_reg[0] = p0;
    bus.retire_phys_reg[1] = p1;
    bus.flush              = fl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".map5"},   64'(bus.arch_map[5]), 64'd5);
    chk({tag, ".map12"},  64'(bus.arch_map[12]), 64'd12);
    chk({tag, ".free"},   bus.free_mask, 64'h0);
    chk({tag, ".cnt"},    64'(bus.retired_count), 64'd0);
    chk({tag, ".rcv"},    64'(bus.recover_valid), 64'd0);
    chk({tag, ".err"},    64'(bus.double_map_err), 64'd0);
    chk({tag, ".avail"},  bus.arch_avail_mask, 64'hFFFF_FFFF_0000_0000);
  endtask

  initial begin
    //          v     hd    a0  p0  a1  p1  fl  free                   cnt rcv err ca  map  avail
    vecs[0]  = mk(2'b01, 2'b01, 5, 40, 0, 0, 0, 64'h0000_0000_0000_0020, 1, 0, 0, 5, 40, 64'hFFFF_FEFF_0000_0020);
    vecs[1]  = mk(2'b00, 2'b00, 0, 0,  0, 0, 0, 64'h0,                   0, 0, 0, 5, 40, 64'hFFFF_FEFF_0000_0020);
    vecs[2]  = mk(2'b11, 2'b11, 7, 41, 7, 42,0, 64'h0000_0200_0000_0080, 2, 0, 0, 7, 42, 64'hFFFF_FAFF_0000_00A0);
    vecs[3]  = mk(2'b11, 2'b01, 0, 43, 9, 50,0, 64'h0,                   2, 0, 0, 0, 0,  64'hFFFF_FAFF_0000_00A0);
    vecs[4]  = mk(2'b01, 2'b01, 3, 44, 0, 0, 1, 64'h0000_0000_0000_0008, 1, 1, 0, 3, 44, 64'hFFFF_EAFF_0000_00A8);
    vecs[5]  = mk(2'b00, 2'b00, 0, 0,  0, 0, 0, 64'h0,                   0, 0, 0, 3, 44, 64'hFFFF_EAFF_0000_00A8);
    vecs[6]  = mk(2'b01, 2'b01, 4, 45, 0, 0, 1, 64'h0000_0000_0000_0010, 1, 1, 0, 4, 45, 64'hFFFF_CAFF_0000_00B8);
    vecs[7]  = mk(2'b01, 2'b01, 6, 46, 0, 0, 1, 64'h0000_0000_0000_0040, 1, 1, 0, 6, 46, 64'hFFFF_8AFF_0000_00F8);
    vecs[8]  = mk(2'b00, 2'b00, 0, 0,  0, 0, 0, 64'h0,                   0, 0, 0, 4, 45, 64'hFFFF_8AFF_0000_00F8);
    vecs[9]  = mk(2'b01, 2'b01, 5, 40, 0, 0, 0, 64'h0,                   1, 0, 0, 5, 40, 64'hFFFF_8AFF_0000_00F8);
    vecs[10] = mk(2'b01, 2'b01, 9, 12, 0, 0, 0, 64'h0000_0000_0000_0200, 1, 0, 1, 9, 12, 64'hFFFF_8AFF_0000_02F8);
    vecs[11] = mk(2'b00, 2'b00, 0, 0,  0, 0, 0, 64'h0,                   0, 0, 1, 9, 12, 64'hFFFF_8AFF_0000_02F8);

    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk_reset_state("rst");

    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(vecs[i].v, vecs[i].hd, vecs[i].a0, vecs[i].p0, vecs[i].a1, vecs[i].p1, vecs[i].fl);
      step();
      chk($sformatf("v%0d.free", i),  bus.free_mask, vecs[i].efree);
      chk($sformatf("v%0d.cnt", i),   64'(bus.retired_count), 64'(vecs[i].ecnt));
      chk($sformatf("v%0d.rcv", i),   64'(bus.recover_valid), 64'(vecs[i].ercv));
      chk($sformatf("v%0d.err", i),   64'(bus.double_map_err), 64'(vecs[i].eerr));
      chk($sformatf("v%0d.map", i),   64'(bus.arch_map[vecs[i].ca]), 64'(vecs[i].emap));
      chk($sformatf("v%0d.avail", i), bus.arch_avail_mask, vecs[i].eavail);
    end

    // Reset asserted together with a retire and a flush: reset wins.
    @(negedge clock);
    drive(2'b11, 2'b11, 5, 50, 8, 51, 1'b1);
    reset = 1'b1;
    step();
    chk_reset_state("rst_mid");
    @(negedge clock);
    reset = 1'b0;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    step();
    chk_reset_state("rst_after");

    // Flush with no valid lanes still pulses once, snapshot unchanged.
    @(negedge clock);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    step();
    chk("fl_empty.rcv",   64'(bus.recover_valid), 64'd1);
    chk("fl_empty.avail", bus.arch_avail_mask, 64'hFFFF_FFFF_0000_0000);
    @(negedge clock);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    step();
    chk("fl_empty.drop",  64'(bus.recover_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
